// File: rtl/mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_stage : memory-access pipeline stage between EXE and WB.             |
// | Loads/stores over a req/ack data-memory port; other ops pass in 1 cycle. |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module mem_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] IR_in,
    input  logic [WIDTH-3:0] PC_in,
    input  logic [WIDTH-1:0] Z,
    input  logic [WIDTH-1:0] Addr,
    output logic             IsStall,
    output logic [WIDTH-1:0] IR_out,
    output logic [WIDTH-3:0] PC_out,
    output logic [WIDTH-1:0] Z_out,
    output logic [WIDTH-1:0] LMD,
    output logic [WIDTH-1:0] LMD_hi,
    output logic             MisalignErr,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [3:0]       dmem_be,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    input  logic [WIDTH-1:0] dmem_rdata,
    input  logic             dmem_ack
);

    localparam logic [5:0] OP_NOP = 6'h00;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LD  = 6'h37;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_SD  = 6'h3F;
    localparam logic [WIDTH-1:0] NOP_IR = {OP_NOP, {(WIDTH-6){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC1 = 2'd1,
        S_ACC2 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ir_q, ir_d, z_q, z_d, addr_q, addr_d, lo_q, lo_d;
    logic [WIDTH-3:0] pc_q, pc_d;
    logic [WIDTH-1:0] ir_out_q, ir_out_d, z_out_q, z_out_d;
    logic [WIDTH-1:0] lmd_q, lmd_d, lmd_hi_q, lmd_hi_d;
    logic [WIDTH-3:0] pc_out_q, pc_out_d;
    logic             misalign_q, misalign_d;

    logic [5:0]       op_in, op_q;
    logic [WIDTH-1:0] word_addr;
    logic [15:0]      rd_half;
    logic [WIDTH-1:0] rd_half_sext;

    // A case match never hits an x opcode, so unknown IR decodes as non-memory.
    function automatic logic is_mem_op(input logic [5:0] op);
        case (op)
            OP_LW, OP_LH, OP_LD, OP_SW, OP_SH, OP_SD: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

    function automatic logic is_half_op(input logic [5:0] op);
        case (op)
            OP_LH, OP_SH: return 1'b1;
            default:      return 1'b0;
        endcase
    endfunction

    assign op_in        = IR_in[WIDTH-1 -: 6];
    assign op_q         = ir_q[WIDTH-1 -: 6];
    assign word_addr    = {addr_q[WIDTH-1:2], 2'b00};
    assign rd_half      = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    assign rd_half_sext = {{(WIDTH-16){rd_half[15]}}, rd_half};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ir_q       <= '0;
            pc_q       <= '0;
            z_q        <= '0;
            addr_q     <= '0;
            lo_q       <= '0;
            ir_out_q   <= NOP_IR;
            pc_out_q   <= '0;
            z_out_q    <= '0;
            lmd_q      <= '0;
            lmd_hi_q   <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            pc_q       <= pc_d;
            z_q        <= z_d;
            addr_q     <= addr_d;
            lo_q       <= lo_d;
            ir_out_q   <= ir_out_d;
            pc_out_q   <= pc_out_d;
            z_out_q    <= z_out_d;
            lmd_q      <= lmd_d;
            lmd_hi_q   <= lmd_hi_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        pc_d       = pc_q;
        z_d        = z_q;
        addr_d     = addr_q;
        lo_d       = lo_q;
        ir_out_d   = ir_out_q;
        pc_out_d   = pc_out_q;
        z_out_d    = z_out_q;
        lmd_d      = lmd_q;
        lmd_hi_d   = lmd_hi_q;
        misalign_d = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_be    = 4'b0000;
        dmem_addr  = '0;
        dmem_wdata = '0;

        case (state_q)
            S_IDLE: begin
                if (!is_mem_op(op_in)) begin
                    ir_out_d = IR_in;
                    pc_out_d = PC_in;
                    z_out_d  = Z;
                    lmd_d    = '0;
                    lmd_hi_d = '0;
                end else if (is_half_op(op_in) ? Addr[0] : (Addr[1:0] != 2'b00)) begin
                    misalign_d = 1'b1;
                    ir_out_d   = NOP_IR;
                end else begin
                    ir_d     = IR_in;
                    pc_d     = PC_in;
                    z_d      = Z;
                    addr_d   = Addr;
                    ir_out_d = NOP_IR;
                    state_d  = S_ACC1;
                end
            end

            S_ACC1: begin
                dmem_req  = 1'b1;
                dmem_addr = word_addr;
                dmem_be   = is_half_op(op_q) ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
                case (op_q)
                    OP_SW, OP_SD: begin
                        dmem_we    = 1'b1;
                        dmem_wdata = z_q;
                    end
                    OP_SH: begin
                        dmem_we    = 1'b1;
                        dmem_wdata = {z_q[15:0], z_q[15:0]};
                    end
                    default: ;
                endcase
                if (dmem_ack) begin
                    if (op_q == OP_LD || op_q == OP_SD) begin
                        lo_d    = (op_q == OP_LD) ? dmem_rdata : '0;
                        state_d = S_ACC2;
                    end else begin
                        ir_out_d = ir_q;
                        pc_out_d = pc_q;
                        z_out_d  = z_q;
                        lmd_hi_d = '0;
                        case (op_q)
                            OP_LW:   lmd_d = dmem_rdata;
                            OP_LH:   lmd_d = rd_half_sext;
                            default: lmd_d = '0;
                        endcase
                        state_d = S_IDLE;
                    end
                end
            end

            S_ACC2: begin
                // Second word of a double access; the add wraps at the top of memory.
                dmem_req  = 1'b1;
                dmem_addr = word_addr + WIDTH'(4);
                dmem_be   = 4'b1111;
                if (op_q == OP_SD) begin
                    dmem_we    = 1'b1;
                    dmem_wdata = {WIDTH{z_q[WIDTH-1]}};
                end
                if (dmem_ack) begin
                    ir_out_d = ir_q;
                    pc_out_d = pc_q;
                    z_out_d  = z_q;
                    lmd_d    = lo_q;
                    lmd_hi_d = (op_q == OP_LD) ? dmem_rdata : '0;
                    state_d  = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign IsStall     = (state_q != S_IDLE);
    assign IR_out      = ir_out_q;
    assign PC_out      = pc_out_q;
    assign Z_out       = z_out_q;
    assign LMD         = lmd_q;
    assign LMD_hi      = lmd_hi_q;
    assign MisalignErr = misalign_q;

endmodule
`default_nettype wire
